// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request sequencer in front of a 64 KB asynchronous RAM.
// Each accepted single-beat read/write request becomes a registered
// SETUP -> ACCESS -> RECOVER pin sequence on chip_en/wr_en/rd_en/addr/data_in.
// The result (read data or write completion) goes out on a valid/ready
// response port. Completed reads and writes are counted with saturation.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready is combinational)
//   req_wr/addr/wdata     request payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_wr, rsp_rdata     response payload (rdata is 0x00 for writes)
//   chip_en/wr_en/rd_en   RAM controls (registered)
//   addr, data_in         RAM address / write data (registered)
//   data_out              RAM read data
//   busy                  sequencer is not idle
//   rd_count, wr_count    saturating completion counters
module ram_req_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [7:0]  rsp_rdata,
  output logic        chip_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [15:0] addr,
  output logic [7:0]  data_in,
  input  logic [7:0]  data_out,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned MAX_CYC = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Phase lengths of zero would make the strobe sequence meaningless.
  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("ram_req_ctrl: SETUP_CYC must be >= 1");
  end
  if (ACCESS_CYC < 1) begin : g_bad_access
    $error("ram_req_ctrl: ACCESS_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cur_wr;

  // A pending response blocks new requests: one transaction outstanding.
  assign req_ready = (state == IDLE) && !rsp_valid;
  assign busy      = (state != IDLE);

  // Sequencer: phase timing, RAM pins, response and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_wr    <= 1'b0;
      chip_en   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= 16'h0000;
      data_in   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= 8'h00;
      rd_count  <= 16'h0000;
      wr_count  <= 16'h0000;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state   <= SETUP;
            cnt     <= '0;
            cur_wr  <= req_wr;
            chip_en <= 1'b1;
            addr    <= req_addr;
            data_in <= req_wdata;
          end
        end

        SETUP: begin
          if (cnt == CNT_W'(SETUP_CYC - 1)) begin
            state <= ACCESS;
            cnt   <= '0;
            wr_en <= cur_wr;
            rd_en <= !cur_wr;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ACCESS: begin
          if (cnt == CNT_W'(ACCESS_CYC - 1)) begin
            // Strobe ends here; read data is sampled while rd_en is still high.
            state     <= RECOVER;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_wr    <= cur_wr;
            rsp_rdata <= cur_wr ? 8'h00 : data_out;
            if (cur_wr) begin
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RECOVER: begin
          // Hold cycle: addr/data_in stay put while chip_en is still asserted.
          state   <= IDLE;
          chip_en <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

Request-side sequencer that sits directly upstream of the 64 KB asynchronous RAM and drives its pins: chip_en, wr_en, rd_en, addr, data_in, with data_out sampled back. Accepts single-beat read/write requests over a valid/ready handshake and expands each into registered, glitch-free setup / strobe / recovery phases. Returns read data, or write completion, over a valid/ready response port. Keeps saturating read and write transaction counters for the monitor side.

## Interface
- SETUP_CYC, 1, cycles chip_en and addr are stable before the strobe; must be ≥1, elaboration error otherwise
- ACCESS_CYC, 2, cycles the rd_en/wr_en strobe is held; must be ≥1, elaboration error otherwise
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all flops clear on assertion, release is synchronous to clk
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; combinational: state==IDLE && !rsp_valid
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  byte address
- req_wdata  in  8  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_wr  out  1  echo of req_wr for this response
- rsp_rdata  out  8  read data; 0x00 for write responses
- chip_en, wr_en, rd_en  out  1 each  RAM controls, all registered
- addr  out  16  RAM address, registered
- data_in  out  8  RAM write data, registered
- data_out  in  8  RAM read data
- busy  out  1  state != IDLE
- rd_count, wr_count  out  16 each  completed reads / writes, saturate at 0xFFFF

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE:
  - Strobes are 0.
  - A request is accepted on a cycle with req_valid && req_ready.
  - On acceptance, latch req_wr/req_addr/req_wdata into addr/data_in and go to SETUP.
- SETUP:
  - chip_en=1 and addr is held; wr_en=rd_en=0.
  - Lasts SETUP_CYC cycles, then goes to ACCESS.
- ACCESS:
  - chip_en=1, plus wr_en=1 for a write or rd_en=1 for a read.
  - Lasts ACCESS_CYC cycles.
  - For a read, data_out is captured into rsp_rdata at the edge that ends the last ACCESS cycle.
  - That same edge sets rsp_valid, loads rsp_wr, and increments the matching counter (saturating).
- RECOVER:
  - One cycle with chip_en=1, strobes 0, and addr/data_in held (hold time).
  - Then go to IDLE.
- wr_en and rd_en are never 1 at the same time.
- Neither strobe is ever 1 while chip_en is 0.
- addr/data_in change only at request acceptance.
- Response:
  - rsp_valid stays 1, with rsp_rdata/rsp_wr stable, until a cycle with rsp_valid && rsp_ready.
  - rsp_valid clears at that edge.
  - While rsp_valid=1, req_ready=0. At most one transaction is outstanding; responses never overlap.
- req_valid and the request fields are ignored unless req_ready=1.
- Address 0xFFFF and 0x0000 need no special handling; there is no wrap logic.

## Timing
- Reset values: chip_en=wr_en=rd_en=0, addr=0x0000, data_in=0x00, rsp_valid=0, rsp_wr=0, rsp_rdata=0x00, busy=0, rd_count=wr_count=0, state=IDLE.
- Reset asserted mid-transaction: strobes drop immediately (asynchronous), the transaction is discarded, no response is produced, and counters clear.
- Request accepted at edge E. Cycle numbering below is counted after E.
- Defaults (SETUP_CYC=1, ACCESS_CYC=2):
  - cycle 1: SETUP
  - cycles 2–3: ACCESS
  - cycle 4: RECOVER, with rsp_valid=1
  - cycle 5: IDLE
- General case: rsp_valid rises at the start of cycle SETUP_CYC+ACCESS_CYC+1.
- If rsp_ready=1 during RECOVER, req_ready=1 in cycle SETUP_CYC+ACCESS_CYC+2.
- Peak throughput: one transaction every SETUP_CYC+ACCESS_CYC+2 cycles (5 at defaults).
- rsp_ready low stalls the controller in IDLE with req_ready=0. No RAM activity occurs during the stall.
- Counter increment and rsp_valid set happen on the same edge.
- A counter at 0xFFFF stays at 0xFFFF.

## Test plan
- Reset: hold reset=0 for 3 cycles with req_valid=1 → all outputs at their reset values, nothing accepted, no strobes. After release, req_ready=1 on the first cycle.
- Write then read: write 0xA5 to 0x1234, then read 0x1234 against the RAM model.
  - Write: wr_en high exactly cycles 2–3, rsp_valid at cycle 4 with rsp_wr=1 and rsp_rdata=0x00.
  - Read: rsp_rdata=0xA5 with rsp_wr=0.
  - Counters end at wr_count=1, rd_count=1.
- Back-to-back: req_valid held high with rsp_ready=1, 4 writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 → accepts spaced exactly 5 cycles apart. Data reads back correctly at all four addresses.
- Backpressure: read with rsp_ready=0 for 6 cycles → rsp_valid and rsp_rdata stable, req_ready=0, chip_en=0 throughout. Release → rsp_valid clears, then the next request is accepted.
- Reset mid-op: assert reset during the second ACCESS cycle of a write → wr_en and chip_en fall without waiting for clk, no rsp_valid, wr_count=0.
- Parameters: SETUP_CYC=3, ACCESS_CYC=1, read → chip_en high 5 cycles, rd_en high 1 cycle, rsp_valid at cycle 5. Assertions hold throughout: no rd_en&&wr_en, no strobe without chip_en.
